spring_particle_n: RTL and testbench

Parametrised spring-mass particle for the 16x16 soft-body grid simulation. It advances one particle by one Verlet time step per `start` pulse. Each step applies an external force and a damped spring interaction with `N_NEIGH` neighbour particles, all through a single time-shared signed multiplier, then clamps the result to the grid walls. Unlike the free-running fixed-phase particle, it is started and completed by a `start`/`done` handshake, so a top-level scheduler can sequence any number of particles, and all arithmetic saturates instead of wrapping.

---
 rtl/spring_particle_n.sv | 206 ++++++++++++++++++++
 tb/tb_spring_particle_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spring_particle_n.sv
// One Verlet step of a spring-mass particle per start pulse. All neighbour terms
// share a single saturating fixed-point multiplier.
module spring_particle_n #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 4,
  parameter int N_NEIGH     = 3,
  parameter int GRID        = 256,
  parameter int INIT_X      = 128,
  parameter int INIT_Y      = 128,
  parameter int REST        = 64,
  parameter int MASS_SHIFT  = 3,
  parameter int DAMP_SHIFT  = 2,
  parameter int FORCE_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [WIDTH-1:0]    force_x,
  input  logic signed [WIDTH-1:0]    force_y,
  input  logic [N_NEIGH*WIDTH-1:0]   nb_x,
  input  logic [N_NEIGH*WIDTH-1:0]   nb_y,
  input  logic [N_NEIGH*WIDTH-1:0]   nb_vx,
  input  logic [N_NEIGH*WIDTH-1:0]   nb_vy,
  output logic                       busy,
  output logic                       done,
  output logic signed [WIDTH-1:0]    x,
  output logic signed [WIDTH-1:0]    y,
  output logic signed [WIDTH-1:0]    vel_x,
  output logic signed [WIDTH-1:0]    vel_y
);
  localparam int KW = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_NEIGH - 1);
  localparam logic signed [WIDTH-1:0] S_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] X_RST    = WIDTH'(INIT_X);
  localparam logic signed [WIDTH-1:0] Y_RST    = WIDTH'(INIT_Y);
  localparam logic signed [WIDTH-1:0] GRID_W   = WIDTH'(GRID);
  localparam logic signed [WIDTH-1:0] GRID_TOP = WIDTH'(GRID - 1);
  localparam logic signed [WIDTH-1:0] REST_W   = WIDTH'(REST);

  typedef enum logic [3:0] {
    S_IDLE, S_INT, S_DX, S_MX, S_MY, S_DIST, S_DMPX, S_DMPY,
    S_DAMP, S_FX, S_FY, S_CLAMP, S_DONE
  } state_t;

  function automatic logic signed [WIDTH-1:0] sat_ext(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? S_MIN : S_MAX;
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] add_s(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return sat_ext({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic logic signed [WIDTH-1:0] sub_s(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return sat_ext({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, x_old_q, x_old_d, y_old_q, y_old_d;
  logic signed [WIDTH-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d, ax_q, ax_d, ay_q, ay_d;
  logic signed [WIDTH-1:0] dx_q, dx_d, dy_q, dy_d, dx2_q, dx2_d, dy2_q, dy2_d;
  logic signed [WIDTH-1:0] disp_q, disp_d, rvx_q, rvx_d, rvy_q, rvy_d;
  logic signed [WIDTH-1:0] dpx_q, dpx_d, dpy_q, dpy_d, damp_q, damp_d;
  logic busy_q, busy_d, done_q, done_d;

  logic signed [WIDTH-1:0] nbx_k, nby_k, nbvx_k, nbvy_k;
  logic signed [WIDTH-1:0] xn, yn, dsum, spring_f;
  logic signed [WIDTH-1:0] mul_a, mul_b, prod;
  logic signed [2*WIDTH-1:0] prod_full, prod_sh;
  logic last_k;

  assign nbx_k  = nb_x[k_q*WIDTH +: WIDTH];
  assign nby_k  = nb_y[k_q*WIDTH +: WIDTH];
  assign nbvx_k = nb_vx[k_q*WIDTH +: WIDTH];
  assign nbvy_k = nb_vy[k_q*WIDTH +: WIDTH];
  assign last_k = (k_q == K_LAST);

  assign xn = add_s(add_s(sub_s(add_s(x_q, x_q), x_old_q), ax_q >>> 2), force_x >>> FORCE_SHIFT);
  assign yn = add_s(add_s(sub_s(add_s(y_q, y_q), y_old_q), ay_q >>> 2), force_y >>> FORCE_SHIFT);
  assign dsum     = add_s(dx2_q, dy2_q);
  assign spring_f = add_s(disp_q >>> MASS_SHIFT, damp_q);

  // The only multiplier: product rescaled by FRAC, then saturated back to WIDTH.
  assign prod_full = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
  assign prod_sh   = prod_full >>> FRAC;
  assign prod = ((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]))
              ? prod_sh[WIDTH-1:0] : (prod_sh[2*WIDTH-1] ? S_MIN : S_MAX);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MX:    begin mul_a = dx_q;     mul_b = dx_q;        end
      S_MY:    begin mul_a = dy_q;     mul_b = dy_q;        end
      S_DMPX:  begin mul_a = rvx_q;    mul_b = dx_q;        end
      S_DMPY:  begin mul_a = rvy_q;    mul_b = dy_q;        end
      S_FX:    begin mul_a = spring_f; mul_b = dx_q >>> 2;  end
      S_FY:    begin mul_a = spring_f; mul_b = dy_q >>> 2;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;  k_d = k_q;
    x_d = x_q;          y_d = y_q;
    x_old_d = x_old_q;  y_old_d = y_old_q;
    vel_x_d = vel_x_q;  vel_y_d = vel_y_q;
    ax_d = ax_q;        ay_d = ay_q;
    dx_d = dx_q;        dy_d = dy_q;
    dx2_d = dx2_q;      dy2_d = dy2_q;
    disp_d = disp_q;    rvx_d = rvx_q;    rvy_d = rvy_q;
    dpx_d = dpx_q;      dpy_d = dpy_q;    damp_d = damp_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_INT;
      S_INT: begin
        x_old_d = x_q;
        y_old_d = y_q;
        vel_x_d = sub_s(xn, x_q) >>> 1;
        vel_y_d = sub_s(yn, y_q) >>> 1;
        x_d     = xn;
        y_d     = yn;
        ax_d    = '0;
        ay_d    = '0;
        k_d     = '0;
        state_d = S_DX;
      end
      S_DX: begin
        dx_d    = sub_s(x_q, nbx_k);
        dy_d    = sub_s(y_q, nby_k);
        state_d = S_MX;
      end
      S_MX: begin dx2_d = prod; state_d = S_MY;   end
      S_MY: begin dy2_d = prod; state_d = S_DIST; end
      S_DIST: begin
        // Coincident neighbour exerts no force; move straight on to the next one.
        if (dsum <= 0) begin
          if (last_k) state_d = S_CLAMP;
          else begin k_d = k_q + KW'(1); state_d = S_DX; end
        end else begin
          disp_d  = sub_s(dsum, REST_W);
          rvx_d   = sub_s(vel_x_q, nbvx_k);
          rvy_d   = sub_s(vel_y_q, nbvy_k);
          state_d = S_DMPX;
        end
      end
      S_DMPX: begin dpx_d = prod; state_d = S_DMPY; end
      S_DMPY: begin dpy_d = prod; state_d = S_DAMP; end
      S_DAMP: begin damp_d = add_s(dpx_q, dpy_q) >>> DAMP_SHIFT; state_d = S_FX; end
      S_FX:   begin ax_d = sub_s(ax_q, prod); state_d = S_FY; end
      S_FY: begin
        ay_d = sub_s(ay_q, prod);
        if (last_k) state_d = S_CLAMP;
        else begin k_d = k_q + KW'(1); state_d = S_DX; end
      end
      S_CLAMP: begin
        if (x_q[WIDTH-1]) begin x_d = '0; vel_x_d = -(vel_x_q >>> 1); end
        else if (x_q >= GRID_W) begin x_d = GRID_TOP; vel_x_d = -(vel_x_q >>> 1); end
        if (y_q[WIDTH-1]) begin y_d = '0; vel_y_d = -(vel_y_q >>> 1); end
        else if (y_q >= GRID_W) begin y_d = GRID_TOP; vel_y_d = -(vel_y_q >>> 1); end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  k_q <= '0;
      x_q <= X_RST;       y_q <= Y_RST;
      x_old_q <= X_RST;   y_old_q <= Y_RST;
      vel_x_q <= '0;      vel_y_q <= '0;
      ax_q <= '0;         ay_q <= '0;
      dx_q <= '0;         dy_q <= '0;
      dx2_q <= '0;        dy2_q <= '0;
      disp_q <= '0;       rvx_q <= '0;     rvy_q <= '0;
      dpx_q <= '0;        dpy_q <= '0;     damp_q <= '0;
      busy_q <= 1'b0;     done_q <= 1'b0;
    end else begin
      state_q <= state_d; k_q <= k_d;
      x_q <= x_d;         y_q <= y_d;
      x_old_q <= x_old_d; y_old_q <= y_old_d;
      vel_x_q <= vel_x_d; vel_y_q <= vel_y_d;
      ax_q <= ax_d;       ay_q <= ay_d;
      dx_q <= dx_d;       dy_q <= dy_d;
      dx2_q <= dx2_d;     dy2_q <= dy2_d;
      disp_q <= disp_d;   rvx_q <= rvx_d;  rvy_q <= rvy_d;
      dpx_q <= dpx_d;     dpy_q <= dpy_d;  damp_q <= damp_d;
      busy_q <= busy_d;   done_q <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x     = x_q;
  assign y     = y_q;
  assign vel_x = vel_x_q;
  assign vel_y = vel_y_q;
endmodule

// File: tb/tb_spring_particle_n.sv
// Bench for spring_particle_n: directed scenarios plus randomized steps, all
// checked against an integer-arithmetic model of one Verlet step.
module tb_spring_particle_n;
  localparam int W    = 16;
  localparam int N    = 3;
  localparam int INIT = 128;

  logic clk = 1'b0;
  logic reset, start;
  logic signed [W-1:0] force_x, force_y;
  logic [N*W-1:0] nb_x, nb_y, nb_vx, nb_vy;
  logic busy, done;
  logic signed [W-1:0] x, y, vel_x, vel_y;

  always #5 clk = ~clk;

  spring_particle_n dut (
    .clk(clk), .reset(reset), .start(start),
    .force_x(force_x), .force_y(force_y),
    .nb_x(nb_x), .nb_y(nb_y), .nb_vx(nb_vx), .nb_vy(nb_vy),
    .busy(busy), .done(done),
    .x(x), .y(y), .vel_x(vel_x), .vel_y(vel_y)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference particle state and the stimulus for the next step
  int m_x, m_y, m_xo, m_yo, m_vx, m_vy, m_ax, m_ay;
  int nbx[N], nby[N], nbvx[N], nbvy[N];
  int fx, fy;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int sadd(int a, int b);
    return sat16(longint'(a) + longint'(b));
  endfunction

  function automatic int ssub(int a, int b);
    return sat16(longint'(a) - longint'(b));
  endfunction

  function automatic int fmul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat16(p >>> 4);
  endfunction

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic modelReset();
    m_x = INIT; m_y = INIT; m_xo = INIT; m_yo = INIT;
    m_vx = 0; m_vy = 0; m_ax = 0; m_ay = 0;
  endtask

  task automatic modelStep(output int doneEdge);
    int xn, yn, dx, dy, d, disp, rvx, rvy, damp, f;
    xn = sadd(sadd(ssub(sadd(m_x, m_x), m_xo), m_ax >>> 2), fx >>> 4);
    yn = sadd(sadd(ssub(sadd(m_y, m_y), m_yo), m_ay >>> 2), fy >>> 4);
    m_xo = m_x; m_yo = m_y;
    m_vx = ssub(xn, m_x) >>> 1;
    m_vy = ssub(yn, m_y) >>> 1;
    m_x = xn; m_y = yn;
    m_ax = 0; m_ay = 0;
    doneEdge = 3;
    for (int k = 0; k < N; k++) begin
      dx = ssub(m_x, nbx[k]);
      dy = ssub(m_y, nby[k]);
      d  = sadd(fmul(dx, dx), fmul(dy, dy));
      if (d <= 0) begin
        doneEdge += 4;
      end else begin
        disp = ssub(d, 64);
        rvx  = ssub(m_vx, nbvx[k]);
        rvy  = ssub(m_vy, nbvy[k]);
        damp = sadd(fmul(rvx, dx), fmul(rvy, dy)) >>> 2;
        f    = sadd(disp >>> 3, damp);
        m_ax = ssub(m_ax, fmul(f, dx >>> 2));
        m_ay = ssub(m_ay, fmul(f, dy >>> 2));
        doneEdge += 9;
      end
    end
    if (m_x < 0)          begin m_x = 0;   m_vx = -(m_vx >>> 1); end
    else if (m_x >= 256)  begin m_x = 255; m_vx = -(m_vx >>> 1); end
    if (m_y < 0)          begin m_y = 0;   m_vy = -(m_vy >>> 1); end
    else if (m_y >= 256)  begin m_y = 255; m_vy = -(m_vy >>> 1); end
  endtask

  task automatic applyStimulus();
    force_x = W'(fx);
    force_y = W'(fy);
    for (int k = 0; k < N; k++) begin
      nb_x[k*W +: W]  = W'(nbx[k]);
      nb_y[k*W +: W]  = W'(nby[k]);
      nb_vx[k*W +: W] = W'(nbvx[k]);
      nb_vy[k*W +: W] = W'(nbvy[k]);
    end
  endtask

  task automatic setNeighbour(input int k, input int px, input int py, input int pvx, input int pvy);
    nbx[k] = px; nby[k] = py; nbvx[k] = pvx; nbvy[k] = pvy;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // Edge 0 is the edge that samples start; startAt/resetAt of 0 mean "none".
  task automatic runStep(input string tag, input int startAt, input int resetAt);
    int expEdge, e, doneAt, dones;
    modelStep(expEdge);
    if (resetAt > 0) modelReset();
    applyStimulus();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e = 0; doneAt = -1; dones = 0;
    while (e <= expEdge + 3) begin
      if (e == startAt - 1) start = 1'b1;
      if (e == startAt)     start = 1'b0;
      if (e == resetAt - 1) reset = 1'b1;
      if (resetAt > 0 && e == resetAt) begin
        checkOutput({tag, "_rst_busy"}, int'(busy), 0);
        checkOutput({tag, "_rst_x"}, int'(x), INIT);
        reset = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (doneAt < 0) doneAt = e + 1;
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    reset = 1'b0;
    if (resetAt > 0) begin
      checkOutput({tag, "_done_count"}, dones, 0);
    end else begin
      checkOutput({tag, "_done_edge"}, doneAt, expEdge);
      checkOutput({tag, "_done_count"}, dones, 1);
    end
    checkOutput({tag, "_busy_idle"}, int'(busy), 0);
    checkOutput({tag, "_x"}, int'(x), m_x);
    checkOutput({tag, "_y"}, int'(y), m_y);
    checkOutput({tag, "_vel_x"}, int'(vel_x), m_vx);
    checkOutput({tag, "_vel_y"}, int'(vel_y), m_vy);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startAt, resetAt, nmode;
    reset = 1'b1; start = 1'b0; fx = 0; fy = 0;
    for (int k = 0; k < N; k++) setNeighbour(k, 0, 0, 0, 0);
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("reset_x", int'(x), 128);
    checkOutput("reset_y", int'(y), 128);
    checkOutput("reset_vel_x", int'(vel_x), 0);
    checkOutput("reset_vel_y", int'(vel_y), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    reset = 1'b0;
    modelReset();

    // Every neighbour coincident with the particle: all skipped
    for (int k = 0; k < N; k++) setNeighbour(k, 128, 128, 0, 0);
    runStep("allskip", 0, 0);
    checkOutput("allskip_x_const", int'(x), 128);

    // External force only
    fx = 256;
    for (int k = 0; k < N; k++) setNeighbour(k, 144, 128, 8, 0);
    runStep("force", 0, 0);
    checkOutput("force_x_const", int'(x), 144);
    checkOutput("force_vel_const", int'(vel_x), 8);

    // Huge force drives the particle through the wall
    doReset();
    fx = 32767;
    for (int k = 0; k < N; k++) setNeighbour(k, 2175, 128, 0, 0);
    runStep("wall", 0, 0);
    checkOutput("wall_x_const", int'(x), 255);
    checkOutput("wall_vel_const", int'(vel_x), -511);

    // Single active spring; its acceleration shows up one step later
    doReset();
    fx = 0;
    setNeighbour(0, 192, 128, 0, 0);
    for (int k = 1; k < N; k++) setNeighbour(k, 128, 128, 0, 0);
    runStep("spring1", 0, 0);
    checkOutput("spring1_x_const", int'(x), 128);
    runStep("spring2", 0, 0);
    checkOutput("spring2_x_const", int'(x), 134);

    runStep("startbusy", 5, 0);
    runStep("midreset", 0, 7);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       begin fx = rnd(-512, 511);     fy = rnd(-512, 511);     end
        1:       begin fx = rnd(-64, 63);       fy = rnd(-64, 63);       end
        2:       begin fx = rnd(-32768, 32767); fy = rnd(-32768, 32767); end
        default: begin fx = 0;                  fy = 0;                  end
      endcase
      for (int k = 0; k < N; k++) begin
        nmode = int'($urandom_range(0, 3));
        case (nmode)
          0: setNeighbour(k, m_x + rnd(-3, 3), m_y + rnd(-3, 3), rnd(-16, 16), rnd(-16, 16));
          1: setNeighbour(k, rnd(0, 255), rnd(0, 255), rnd(-16, 16), rnd(-16, 16));
          2: setNeighbour(k, rnd(-32768, 32767), rnd(-32768, 32767),
                          rnd(-32768, 32767), rnd(-32768, 32767));
          default: setNeighbour(k, m_x + rnd(-40, 40), m_y + rnd(-40, 40), rnd(-16, 16), rnd(-16, 16));
        endcase
      end
      startAt = (i % 5 == 0) ? rnd(1, 12) : 0;
      resetAt = (i % 17 == 16 && startAt == 0) ? rnd(1, 14) : 0;
      runStep($sformatf("rand%0d", i), startAt, resetAt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
